// File: rtl/seq_divider_16x8.sv
// seq_divider_16x8: 16/8 unsigned restoring divider that produces one quotient bit per clock, MSB first.
module seq_divider_16x8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        busy,
  output logic        done,
  output logic        dbz
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      r_state, w_next;
  logic        r_zero;
  logic [3:0]  r_cnt;
  logic [15:0] r_dvd;
  logic [7:0]  r_rem, r_b;
  logic [8:0]  w_pr;
  logic        w_ge, w_accept;
  logic [7:0]  w_rem;
  // A zero divisor waits one cycle in IDLE (r_zero) so its result lands one edge after start
  assign w_accept = start && ((r_state == IDLE && !r_zero) || r_state == DONE);
  assign w_pr     = {r_rem, r_dvd[15]};
  assign w_ge     = w_pr >= {1'b0, r_b};
  assign w_rem    = w_ge ? w_pr[7:0] - r_b : w_pr[7:0];
  assign busy     = r_state == RUN;
  assign done     = r_state == DONE;
  always_comb begin
    w_next = r_state == RUN ? (r_cnt == 4'd15 ? DONE : RUN)
           : r_zero ? DONE
           : (w_accept && B != 8'd0) ? RUN : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_cnt  <= 4'd0;
      r_dvd  <= 16'd0;
      r_rem  <= 8'd0;
      r_b    <= 8'd0;
      Q      <= 16'd0;
      R      <= 8'd0;
      dbz    <= 1'b0;
    end else begin
      r_zero <= w_accept && B == 8'd0;
      if (w_accept) begin
        r_dvd <= A;
        r_b   <= B;
        r_rem <= 8'd0;
        r_cnt <= 4'd0;
      end else if (busy) begin
        r_dvd <= {r_dvd[14:0], w_ge};
        r_rem <= w_rem;
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          Q   <= {r_dvd[14:0], w_ge};
          R   <= w_rem;
          dbz <= 1'b0;
        end
      end else if (r_zero) begin
        Q   <= 16'hFFFF;
        R   <= 8'h00;
        dbz <= 1'b1;
      end
    end
  end
endmodule
